// File: rtl/difftest_step_scheduler_if.sv
// Request/response channel between the step scheduler and the shared DPI step engine.
interface difftest_step_scheduler_if #(
    parameter int NUM_CORES = 2,
    parameter int STEP_W    = 8
);
    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic              req_valid;
    logic [CORE_W-1:0] req_core;
    logic [STEP_W-1:0] req_nstep;
    logic              req_ready;
    logic              rsp_valid;
    logic [7:0]        rsp_result;

    modport master (
        output req_valid, req_core, req_nstep,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_core, req_nstep,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/difftest_step_scheduler.sv
// Round-robin sharing of one nstep engine among several cores' commit-step streams,
// with sticky done/fail/overflow flags and per-core stuck detection.
module difftest_step_scheduler #(
    parameter int NUM_CORES = 2,
    parameter int STEP_W    = 8,
    parameter int CNT_W     = 16,
    parameter int STUCK_W   = 32,
    localparam int CORE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CORES*STEP_W-1:0] core_step,
    input  logic [STUCK_W-1:0]          stuck_limit,
    difftest_step_scheduler_if.master   eng,
    output logic                        sim_done,
    output logic                        sim_fail,
    output logic                        overflow,
    output logic                        stuck,
    output logic [CORE_W-1:0]           stuck_core,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HALT = 2'd3} state_t;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [STEP_W-1:0]  STEP_MAX  = '1;
    localparam logic [STUCK_W-1:0] TIMER_MAX = '1;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    pend_r [NUM_CORES];
    logic [CNT_W-1:0]    pend_s [NUM_CORES];
    logic [STUCK_W-1:0]  timer_r [NUM_CORES];
    logic [CNT_W+1:0]    sum_s;
    logic [NUM_CORES-1:0] sat_s;
    logic [CORE_W-1:0]   rr_ptr_r, cand_s, grant_core_s, trip_core_s, req_core_r, stuck_core_r;
    logic [STEP_W-1:0]   grant_nstep_s, req_nstep_r;
    logic                grant_found_s, trip_found_s, handshake_s;
    logic                rsp_ok_s, rsp_done_s, rsp_fail_s;
    logic                req_valid_r, busy_r, sim_done_r, sim_fail_r, overflow_r, stuck_r;

    assign handshake_s   = (state_r == ISSUE) && req_valid_r && eng.req_ready;
    assign eng.req_valid = req_valid_r;
    assign eng.req_core  = req_core_r;
    assign eng.req_nstep = req_nstep_r;
    assign sim_done      = sim_done_r;
    assign sim_fail      = sim_fail_r;
    assign overflow      = overflow_r;
    assign stuck         = stuck_r;
    assign stuck_core    = stuck_core_r;
    assign busy          = busy_r;

    // Next pending count per core: add this cycle's steps, remove an accepted issue, saturate.
    always_comb begin
        pend_s = pend_r;
        sat_s  = '0;
        sum_s  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sum_s = {2'b00, pend_r[i]} + {{(CNT_W-STEP_W+2){1'b0}}, core_step[i*STEP_W +: STEP_W]};
            if (handshake_s && (req_core_r == CORE_W'(i))) begin
                sum_s = sum_s - {{(CNT_W-STEP_W+2){1'b0}}, req_nstep_r};
            end else begin
                sum_s = sum_s;
            end
            if (sum_s > {2'b00, CNT_MAX}) begin
                pend_s[i] = CNT_MAX;
                sat_s[i]  = 1'b1;
            end else begin
                pend_s[i] = sum_s[CNT_W-1:0];
                sat_s[i]  = 1'b0;
            end
        end
    end

    // Round-robin pick: scan downward so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_core_s  = '0;
        cand_s        = '0;
        for (int off = NUM_CORES - 1; off >= 0; off--) begin
            cand_s = CORE_W'((int'(rr_ptr_r) + off) % NUM_CORES);
            if (pend_r[cand_s] != '0) begin
                grant_found_s = 1'b1;
                grant_core_s  = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        if (pend_r[grant_core_s] > CNT_W'(STEP_MAX)) begin
            grant_nstep_s = STEP_MAX;
        end else begin
            grant_nstep_s = pend_r[grant_core_s][STEP_W-1:0];
        end
    end

    // Lowest-indexed core whose idle timer has reached the limit.
    always_comb begin
        trip_found_s = 1'b0;
        trip_core_s  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if ((stuck_limit != '0) && (timer_r[i] >= stuck_limit)) begin
                trip_found_s = 1'b1;
                trip_core_s  = CORE_W'(i);
            end else begin
                trip_found_s = trip_found_s;
            end
        end
    end

    // Engine response decode and FSM next state; a latched failure overrides everything.
    always_comb begin
        state_s    = state_r;
        rsp_ok_s   = 1'b0;
        rsp_done_s = 1'b0;
        rsp_fail_s = 1'b0;
        if ((state_r == WAIT) && eng.rsp_valid) begin
            case (eng.rsp_result)
                8'd0:    rsp_ok_s   = 1'b1;
                8'd1:    rsp_done_s = 1'b1;
                default: rsp_fail_s = 1'b1;
            endcase
        end else begin
            rsp_ok_s = 1'b0;
        end
        case (state_r)
            IDLE:    state_s = sim_fail_r ? HALT : (grant_found_s ? ISSUE : IDLE);
            ISSUE:   state_s = sim_fail_r ? HALT : (handshake_s ? WAIT : ISSUE);
            WAIT: begin
                if (sim_fail_r || rsp_done_s || rsp_fail_s) begin
                    state_s = HALT;
                end else if (rsp_ok_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            HALT:    state_s = HALT;
            default: state_s = HALT;
        endcase
    end

    // FSM, request registers and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            req_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            req_core_r  <= '0;
            req_nstep_r <= '0;
            rr_ptr_r    <= '0;
        end else begin
            state_r     <= state_s;
            req_valid_r <= (state_s == ISSUE);
            busy_r      <= (state_s != IDLE);
            if ((state_r == IDLE) && (state_s == ISSUE)) begin
                req_core_r  <= grant_core_s;
                req_nstep_r <= grant_nstep_s;
            end
            if (handshake_s) begin
                rr_ptr_r <= (req_core_r == CORE_W'(NUM_CORES - 1)) ? '0 : req_core_r + CORE_W'(1);
            end
        end
    end

    // Pending accumulators and idle timers (timers saturate rather than wrap).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                pend_r[i]  <= '0;
                timer_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                pend_r[i] <= pend_s[i];
                if (core_step[i*STEP_W +: STEP_W] != '0) begin
                    timer_r[i] <= '0;
                end else if (timer_r[i] != TIMER_MAX) begin
                    timer_r[i] <= timer_r[i] + STUCK_W'(1);
                end
            end
        end
    end

    // Sticky status flags; stuck_core keeps the first trip only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sim_done_r   <= 1'b0;
            sim_fail_r   <= 1'b0;
            overflow_r   <= 1'b0;
            stuck_r      <= 1'b0;
            stuck_core_r <= '0;
        end else begin
            sim_done_r <= sim_done_r | rsp_done_s;
            sim_fail_r <= sim_fail_r | rsp_fail_s | (|sat_s);
            overflow_r <= overflow_r | (|sat_s);
            if (trip_found_s && !stuck_r) begin
                stuck_r      <= 1'b1;
                stuck_core_r <= trip_core_s;
            end
        end
    end
endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Bench for difftest_step_scheduler: behavioural engine, expected-request scoreboard,
// a stall vector table and hand-written corner-case sequences.
module tb_difftest_step_scheduler;
    localparam int NUM_CORES = 2;
    localparam int STEP_W    = 8;
    localparam int CNT_W     = 16;
    localparam int STUCK_W   = 32;

    logic                        clock = 1'b0;
    logic                        reset = 1'b0;
    logic [NUM_CORES*STEP_W-1:0] core_step;
    logic [STUCK_W-1:0]          stuck_limit;
    logic                        sim_done, sim_fail, overflow, stuck, busy;
    logic [0:0]                  stuck_core;

    difftest_step_scheduler_if #(.NUM_CORES(NUM_CORES), .STEP_W(STEP_W)) bus();

    difftest_step_scheduler #(
        .NUM_CORES(NUM_CORES), .STEP_W(STEP_W), .CNT_W(CNT_W), .STUCK_W(STUCK_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .core_step  (core_step),
        .stuck_limit(stuck_limit),
        .eng        (bus),
        .sim_done   (sim_done),
        .sim_fail   (sim_fail),
        .overflow   (overflow),
        .stuck      (stuck),
        .stuck_core (stuck_core),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [0:0] core; logic [7:0] nstep; } req_t;
    typedef struct packed {
        logic [7:0] step0; logic ready; logic exp_valid; logic [7:0] exp_nstep; logic exp_busy;
    } vec_t;

    req_t       exp_q[$];
    vec_t       tbl [7];
    int         n_checks = 0;
    int         n_errors = 0;
    int         rsp_delay = 0;
    int         rsp_cnt = 0;
    logic       rsp_pending = 1'b0;
    logic [7:0] rsp_code = 8'd0;
    int         issued_sum [NUM_CORES];
    int         driven_sum [NUM_CORES];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_steps(input logic [7:0] s0, input logic [7:0] s1);
        core_step = {s1, s0};
    endtask

    task automatic push_req(input logic [0:0] core, input logic [7:0] nstep);
        req_t e;
        e.core  = core;
        e.nstep = nstep;
        exp_q.push_back(e);
    endtask

    // One clock: score a handshake due at the coming edge, then run the engine's response timer.
    task automatic tick();
        req_t e;
        if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_req: got core %0d nstep %0d expected no request",
                         bus.req_core, bus.req_nstep);
            end else begin
                e = exp_q.pop_front();
                check("req_core", bus.req_core, e.core);
                check("req_nstep", bus.req_nstep, e.nstep);
            end
            issued_sum[bus.req_core] += int'(bus.req_nstep);
            rsp_pending = 1'b1;
            rsp_cnt     = rsp_delay;
        end
        for (int i = 0; i < NUM_CORES; i++) driven_sum[i] += int'(core_step[i*STEP_W +: STEP_W]);
        @(posedge clock);
        #1;
        bus.rsp_valid = 1'b0;
        if (rsp_pending) begin
            if (rsp_cnt == 0) begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_result = rsp_code;
                rsp_pending    = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((busy || rsp_pending || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check(name, (busy == 1'b0 && exp_q.size() == 0) ? 1 : 0, 1);
    endtask

    // Reset asserted mid-cycle so the outputs are checked before any clock edge.
    task automatic do_reset(input bit keep_rsp);
        reset         = 1'b1;
        core_step     = '0;
        bus.rsp_valid = 1'b0;
        if (!keep_rsp) rsp_pending = 1'b0;
        #1;
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_req_core", bus.req_core, 0);
        check("rst_req_nstep", bus.req_nstep, 0);
        check("rst_sim_done", sim_done, 0);
        check("rst_sim_fail", sim_fail, 0);
        check("rst_overflow", overflow, 0);
        check("rst_stuck", stuck, 0);
        check("rst_stuck_core", stuck_core, 0);
        check("rst_busy", busy, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM_CORES; i++) begin
            issued_sum[i] = 0;
            driven_sum[i] = 0;
        end
    endtask

    initial begin
        core_step      = '0;
        stuck_limit    = '0;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_result = 8'd0;
        tbl[0] = '{step0: 8'd2, ready: 1'b0, exp_valid: 1'b0, exp_nstep: 8'd0, exp_busy: 1'b0};
        for (int r = 1; r < 7; r++)
            tbl[r] = '{step0: 8'd2, ready: 1'b0, exp_valid: 1'b1, exp_nstep: 8'd2, exp_busy: 1'b1};
        #2;

        // 1: single burst on core 0.
        do_reset(1'b0);
        bus.req_ready = 1'b1;
        rsp_delay     = 0;
        rsp_code      = 8'd0;
        push_req(1'b0, 8'd3);
        set_steps(8'd3, 8'd0);
        tick();
        set_steps(8'd0, 8'd0);
        tick();
        check("s1_valid", bus.req_valid, 1);
        check("s1_core", bus.req_core, 0);
        check("s1_nstep", bus.req_nstep, 3);
        drain("s1_idle", 50);

        // 2: both cores stepping every cycle, slow engine: grants alternate.
        do_reset(1'b0);
        bus.req_ready = 1'b1;
        rsp_delay     = 2;
        push_req(1'b0, 8'd1);
        push_req(1'b1, 8'd6);
        push_req(1'b0, 8'd10);
        push_req(1'b1, 8'd10);
        push_req(1'b0, 8'd7);
        push_req(1'b1, 8'd2);
        set_steps(8'd1, 8'd1);
        repeat (18) tick();
        set_steps(8'd0, 8'd0);
        drain("s2_idle", 100);
        check("s2_sum0", issued_sum[0], driven_sum[0]);
        check("s2_sum1", issued_sum[1], driven_sum[1]);
        check("s2_total1", driven_sum[1], 18);

        // 3: 300 steps on core 1 split into 255 + 45.
        do_reset(1'b0);
        bus.req_ready = 1'b1;
        rsp_delay     = 5;
        push_req(1'b0, 8'd1);
        push_req(1'b1, 8'd255);
        push_req(1'b1, 8'd45);
        set_steps(8'd1, 8'd0);
        tick();
        set_steps(8'd0, 8'd200);
        tick();
        set_steps(8'd0, 8'd100);
        tick();
        set_steps(8'd0, 8'd0);
        drain("s3_idle", 100);
        check("s3_sum1", issued_sum[1], 300);

        // 4: engine stalls; request must stay stable while pending keeps growing.
        do_reset(1'b0);
        rsp_delay = 0;
        for (int r = 0; r < 7; r++) begin
            set_steps(tbl[r].step0, 8'd0);
            bus.req_ready = tbl[r].ready;
            tick();
            check("s4_valid", bus.req_valid, tbl[r].exp_valid);
            check("s4_core", bus.req_core, 0);
            check("s4_nstep", bus.req_nstep, tbl[r].exp_nstep);
            check("s4_busy", busy, tbl[r].exp_busy);
        end
        set_steps(8'd0, 8'd0);
        bus.req_ready = 1'b1;
        push_req(1'b0, 8'd2);
        push_req(1'b0, 8'd12);
        drain("s4_idle", 50);

        // 5a: DONE halts; pending still accumulates until it saturates.
        do_reset(1'b0);
        bus.req_ready = 1'b1;
        rsp_delay     = 0;
        rsp_code      = 8'd1;
        push_req(1'b0, 8'd1);
        set_steps(8'd1, 8'd0);
        tick();
        set_steps(8'd0, 8'd0);
        repeat (5) tick();
        check("s5_done", sim_done, 1);
        check("s5_fail", sim_fail, 0);
        check("s5_busy", busy, 1);
        check("s5_req_seen", exp_q.size(), 0);
        set_steps(8'd255, 8'd0);
        repeat (256) tick();
        check("s5_no_req", bus.req_valid, 0);
        check("s5_ovf_early", overflow, 0);
        repeat (2) tick();
        check("s5_ovf", overflow, 1);
        check("s5_ovf_fail", sim_fail, 1);

        // 5b: FAIL result.
        do_reset(1'b0);
        bus.req_ready = 1'b1;
        rsp_code      = 8'd2;
        push_req(1'b1, 8'd4);
        set_steps(8'd0, 8'd4);
        tick();
        set_steps(8'd0, 8'd0);
        repeat (6) tick();
        check("s5b_fail", sim_fail, 1);
        check("s5b_done", sim_done, 0);
        check("s5b_ovf", overflow, 0);
        check("s5b_valid", bus.req_valid, 0);

        // 6: core 1 goes quiet; then reset lands while a response is still owed.
        stuck_limit = 32'd10;
        do_reset(1'b0);
        bus.req_ready = 1'b0;
        rsp_delay     = 5;
        set_steps(8'd1, 8'd0);
        repeat (10) tick();
        check("s6_stuck_early", stuck, 0);
        tick();
        check("s6_stuck", stuck, 1);
        check("s6_stuck_core", stuck_core, 1);
        check("s6_no_halt", busy, 1);
        rsp_code      = 8'd2;
        bus.req_ready = 1'b1;
        push_req(1'b0, 8'd1);
        set_steps(8'd0, 8'd0);
        tick();
        tick();
        check("s6_wait_busy", busy, 1);
        check("s6_wait_valid", bus.req_valid, 0);
        stuck_limit = 32'd0;
        do_reset(1'b1);
        repeat (12) tick();
        check("s6_stale_fail", sim_fail, 0);
        check("s6_stale_busy", busy, 0);
        check("s6_limit_off", stuck, 0);
        check("s6_rsp_fired", rsp_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
